decode_issue_stage: RTL and testbench

Parametrised decode/issue stage for the uDLX pipeline. It places a FIFO instruction buffer between fetch and decode, keeps an internal register bank, and tracks in-flight loads in a per-register scoreboard. It issues into a valid/ready ID/EX register toward execute. Fetch supplies the instruction, its PC and pre-decoded fields; this block owns buffering, load-use stalls, flush and issue.

---
 rtl/decode_issue_stage.sv | 186 ++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: FIFO instruction buffer, register bank, load scoreboard and ID/EX register.
// Optional macro DECODE_ISSUE_WB_BYPASS_EN forwards same-cycle writeback data to operand reads.
module decode_issue_stage #(
    parameter int PC_WIDTH          = 20,
    parameter int DATA_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int FIFO_DEPTH        = 4,
    parameter int LOAD_LATENCY      = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          if_valid,
    output logic                          if_ready,
    input  logic [INSTRUCTION_WIDTH-1:0]  if_instruction,
    input  logic [PC_WIDTH-1:0]           if_pc,
    input  logic [REG_ADDR_WIDTH-1:0]     if_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]     if_rs2,
    input  logic                          if_rs1_en,
    input  logic                          if_rs2_en,
    input  logic [REG_ADDR_WIDTH-1:0]     if_rd,
    input  logic                          if_rd_en,
    input  logic                          if_is_load,
    input  logic                          flush,
    input  logic                          wb_write_enable,
    input  logic [REG_ADDR_WIDTH-1:0]     wb_reg_wr_addr,
    input  logic [DATA_WIDTH-1:0]         wb_write_data,
    output logic                          ex_valid,
    input  logic                          ex_ready,
    output logic [INSTRUCTION_WIDTH-1:0]  ex_instruction,
    output logic [PC_WIDTH-1:0]           ex_pc,
    output logic [REG_ADDR_WIDTH-1:0]     ex_rs1,
    output logic [REG_ADDR_WIDTH-1:0]     ex_rs2,
    output logic [REG_ADDR_WIDTH-1:0]     ex_rd,
    output logic                          ex_rd_en,
    output logic                          ex_is_load,
    output logic [DATA_WIDTH-1:0]         ex_data_a,
    output logic [DATA_WIDTH-1:0]         ex_data_b,
    output logic                          stall_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    // The issue cycle is the first advancing cycle, so the counter holds the remaining stall cycles.
    localparam logic [2:0] SB_INIT = 3'(LOAD_LATENCY - 1);

    logic [INSTRUCTION_WIDTH-1:0] buf_instruction [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]          buf_pc          [FIFO_DEPTH];
    logic [REG_ADDR_WIDTH-1:0]    buf_rs1         [FIFO_DEPTH];
    logic [REG_ADDR_WIDTH-1:0]    buf_rs2         [FIFO_DEPTH];
    logic [REG_ADDR_WIDTH-1:0]    buf_rd          [FIFO_DEPTH];
    logic                         buf_rs1_en      [FIFO_DEPTH];
    logic                         buf_rs2_en      [FIFO_DEPTH];
    logic                         buf_rd_en       [FIFO_DEPTH];
    logic                         buf_is_load     [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [DATA_WIDTH-1:0] bank [NUM_REGS];
    logic [2:0]            sb   [NUM_REGS];

    logic                      head_valid;
    logic                      hazard;
    logic                      push;
    logic                      issue;
    logic                      load_set;
    logic [REG_ADDR_WIDTH-1:0] head_rs1;
    logic [REG_ADDR_WIDTH-1:0] head_rs2;
    logic [REG_ADDR_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0]     read_a;
    logic [DATA_WIDTH-1:0]     read_b;

    assign head_rs1   = buf_rs1[rd_ptr];
    assign head_rs2   = buf_rs2[rd_ptr];
    assign head_rd    = buf_rd[rd_ptr];
    assign head_valid = (count != '0);
    assign hazard     = (buf_rs1_en[rd_ptr] && head_rs1 != '0 && sb[head_rs1] != 3'd0) ||
                        (buf_rs2_en[rd_ptr] && head_rs2 != '0 && sb[head_rs2] != 3'd0);
    assign if_ready   = (count != (PTR_W + 1)'(FIFO_DEPTH));
    assign push       = if_valid && if_ready && !flush;
    assign issue      = head_valid && !hazard && (!ex_valid || ex_ready) && !flush;
    assign load_set   = issue && buf_is_load[rd_ptr] && buf_rd_en[rd_ptr] && head_rd != '0;
    assign stall_out  = head_valid && hazard;
    assign fifo_count = count;

    always_comb begin
        read_a = (head_rs1 == '0) ? '0 : bank[head_rs1];
        read_b = (head_rs2 == '0) ? '0 : bank[head_rs2];
`ifdef DECODE_ISSUE_WB_BYPASS_EN
        if (wb_write_enable && wb_reg_wr_addr != '0 && wb_reg_wr_addr == head_rs1)
            read_a = wb_write_data;
        if (wb_write_enable && wb_reg_wr_addr != '0 && wb_reg_wr_addr == head_rs2)
            read_b = wb_write_data;
`endif
    end

    // Buffer storage: data only, pointers and count carry validity.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instruction[wr_ptr] <= if_instruction;
            buf_pc[wr_ptr]          <= if_pc;
            buf_rs1[wr_ptr]         <= if_rs1;
            buf_rs2[wr_ptr]         <= if_rs2;
            buf_rd[wr_ptr]          <= if_rd;
            buf_rs1_en[wr_ptr]      <= if_rs1_en;
            buf_rs2_en[wr_ptr]      <= if_rs2_en;
            buf_rd_en[wr_ptr]       <= if_rd_en;
            buf_is_load[wr_ptr]     <= if_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (issue)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, issue})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ID/EX register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_instruction <= '0;
            ex_pc          <= '0;
            ex_rs1         <= '0;
            ex_rs2         <= '0;
            ex_rd          <= '0;
            ex_rd_en       <= 1'b0;
            ex_is_load     <= 1'b0;
            ex_data_a      <= '0;
            ex_data_b      <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (issue) begin
            ex_valid       <= 1'b1;
            ex_instruction <= buf_instruction[rd_ptr];
            ex_pc          <= buf_pc[rd_ptr];
            ex_rs1         <= head_rs1;
            ex_rs2         <= head_rs2;
            ex_rd          <= head_rd;
            ex_rd_en       <= buf_rd_en[rd_ptr];
            ex_is_load     <= buf_is_load[rd_ptr];
            ex_data_a      <= read_a;
            ex_data_b      <= read_b;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                sb[i] <= 3'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (load_set && head_rd == REG_ADDR_WIDTH'(i))
                    sb[i] <= SB_INIT;
                else if (ex_ready && sb[i] != 3'd0)
                    sb[i] <= sb[i] - 3'd1;
            end
        end
    end

    // Register bank; r0 is never written and always reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                bank[i] <= '0;
        end else if (wb_write_enable && wb_reg_wr_addr != '0) begin
            bank[wb_reg_wr_addr] <= wb_write_data;
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed self-checking bench for decode_issue_stage (default parameters).
module tb_decode_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_instruction = '0;
    logic [19:0] if_pc = '0;
    logic [4:0]  if_rs1 = '0, if_rs2 = '0, if_rd = '0;
    logic        if_rs1_en = 1'b0, if_rs2_en = 1'b0, if_rd_en = 1'b0, if_is_load = 1'b0;
    logic        flush = 1'b0;
    logic        wb_write_enable = 1'b0;
    logic [4:0]  wb_reg_wr_addr = '0;
    logic [31:0] wb_write_data = '0;
    logic        ex_valid;
    logic        ex_ready = 1'b1;
    logic [31:0] ex_instruction;
    logic [19:0] ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_rd_en, ex_is_load;
    logic [31:0] ex_data_a, ex_data_b;
    logic        stall_out;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_fail = 0;

    decode_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_instruction(if_instruction), .if_pc(if_pc),
        .if_rs1(if_rs1), .if_rs2(if_rs2), .if_rs1_en(if_rs1_en), .if_rs2_en(if_rs2_en),
        .if_rd(if_rd), .if_rd_en(if_rd_en), .if_is_load(if_is_load),
        .flush(flush), .wb_write_enable(wb_write_enable), .wb_reg_wr_addr(wb_reg_wr_addr),
        .wb_write_data(wb_write_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instruction(ex_instruction), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rd_en(ex_rd_en), .ex_is_load(ex_is_load),
        .ex_data_a(ex_data_a), .ex_data_b(ex_data_b), .stall_out(stall_out), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [19:0] pc, input logic [4:0] rs1, input logic rs1_en,
                         input logic [4:0] rs2, input logic rs2_en, input logic [4:0] rd,
                         input logic rd_en, input logic ld);
        if_valid       = 1'b1;
        if_pc          = pc;
        if_instruction = {12'hA5C, pc};
        if_rs1 = rs1; if_rs1_en = rs1_en;
        if_rs2 = rs2; if_rs2_en = rs2_en;
        if_rd  = rd;  if_rd_en  = rd_en;
        if_is_load = ld;
    endtask

    task automatic idle();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready: got %b want 1", if_ready); end
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_out); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
        n_checks++; if (ex_pc !== 20'h0 || ex_data_a !== 32'h0) begin n_fail++; $display("FAIL reset_ex_fields: pc %h data_a %h want 0", ex_pc, ex_data_a); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_pc;
        ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(20'h100 + 20'(i), 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
            n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_if_ready[%0d]: got %b want 1", i, if_ready); end
            tick();
            if (i == 0) begin
                n_checks++; if (ex_valid !== 1'b0 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL b2b_first: ex_valid %b count %0d want 0/1", ex_valid, fifo_count); end
            end else begin
                exp_pc = 20'h100 + 20'(i - 1);
                n_checks++; if (ex_valid !== 1'b1 || ex_pc !== exp_pc || fifo_count !== 3'd1) begin n_fail++; $display("FAIL b2b_issue[%0d]: valid %b pc %h count %0d want 1/%h/1", i, ex_valid, ex_pc, fifo_count, exp_pc); end
            end
        end
        n_checks++; if (ex_instruction !== 32'hA5C00102) begin n_fail++; $display("FAIL b2b_instr: got %h want a5c00102", ex_instruction); end
        idle();
        tick();
        n_checks++; if (ex_pc !== 20'h103 || ex_valid !== 1'b1 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL b2b_last: pc %h valid %b count %0d want 103/1/0", ex_pc, ex_valid, fifo_count); end
        tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", ex_valid); end
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(20'h200 + 20'(i), 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
        end
        n_checks++; if (fifo_count !== 3'd4 || if_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: count %0d ready %b want 4/0", fifo_count, if_ready); end
        n_checks++; if (ex_valid !== 1'b1 || ex_pc !== 20'h200) begin n_fail++; $display("FAIL bp_idex: valid %b pc %h want 1/200", ex_valid, ex_pc); end
        drive(20'h205, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        n_checks++; if (fifo_count !== 3'd4 || ex_pc !== 20'h200 || if_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold: count %0d pc %h ready %b want 4/200/0", fifo_count, ex_pc, if_ready); end
        ex_ready = 1'b1;
        tick();
        n_checks++; if (fifo_count !== 3'd3 || ex_pc !== 20'h201) begin n_fail++; $display("FAIL bp_release: count %0d pc %h want 3/201", fifo_count, ex_pc); end
        tick();
        n_checks++; if (fifo_count !== 3'd3 || ex_pc !== 20'h202) begin n_fail++; $display("FAIL bp_fifth_in: count %0d pc %h want 3/202", fifo_count, ex_pc); end
        idle();
        tick();
        tick();
        tick();
        n_checks++; if (fifo_count !== 3'd0 || ex_pc !== 20'h205 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain: count %0d pc %h valid %b want 0/205/1", fifo_count, ex_pc, ex_valid); end
        tick();
    endtask

    task automatic test_load_use();
        ex_ready = 1'b1;
        drive(20'h300, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        drive(20'h301, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        tick();
        idle();
        n_checks++; if (ex_pc !== 20'h300 || ex_is_load !== 1'b1 || ex_rd !== 5'd5) begin n_fail++; $display("FAIL lu_load_issue: pc %h ld %b rd %0d want 300/1/5", ex_pc, ex_is_load, ex_rd); end
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall_out); end
        tick();
        n_checks++; if (stall_out !== 1'b0 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_stall_end: stall %b valid %b want 0/0", stall_out, ex_valid); end
        tick();
        n_checks++; if (ex_pc !== 20'h301 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_dep_issue: pc %h valid %b want 301/1", ex_pc, ex_valid); end
        tick();
        // ex_ready low for three edges after the load issues
        drive(20'h310, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        drive(20'h311, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        tick();
        idle();
        ex_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (stall_out !== 1'b1 || ex_pc !== 20'h310) begin n_fail++; $display("FAIL lu_frozen[%0d]: stall %b pc %h want 1/310", i, stall_out, ex_pc); end
            if (i < 3) tick();
        end
        ex_ready = 1'b1;
        tick();
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL lu_frozen_end: got %b want 0", stall_out); end
        tick();
        n_checks++; if (ex_pc !== 20'h311 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_frozen_issue: pc %h valid %b want 311/1", ex_pc, ex_valid); end
        tick();
    endtask

    task automatic test_flush();
        ex_ready = 1'b1;
        drive(20'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        drive(20'h401, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        ex_ready = 1'b0;
        drive(20'h402, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(20'h403, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        n_checks++; if (fifo_count !== 3'd3 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL fl_pre: count %0d valid %b want 3/1", fifo_count, ex_valid); end
        flush = 1'b1;
        drive(20'h404, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        n_checks++; if (fifo_count !== 3'd0 || ex_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL fl_post: count %0d valid %b ready %b want 0/0/1", fifo_count, ex_valid, if_ready); end
        drive(20'h405, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++; if (stall_out !== 1'b1 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL fl_sb_stall: stall %b count %0d want 1/1", stall_out, fifo_count); end
        tick();
        n_checks++; if (stall_out !== 1'b1 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL fl_sb_hold: stall %b valid %b want 1/0", stall_out, ex_valid); end
        ex_ready = 1'b1;
        tick();
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL fl_sb_clear: got %b want 0", stall_out); end
        tick();
        n_checks++; if (ex_pc !== 20'h405 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL fl_reader: pc %h valid %b want 405/1", ex_pc, ex_valid); end
        tick();
    endtask

    task automatic test_wb();
        logic [31:0] exp_a;
`ifdef DECODE_ISSUE_WB_BYPASS_EN
        exp_a = 32'hDEADBEEF;
`else
        exp_a = 32'h12345678;
`endif
        ex_ready = 1'b1;
        wb_write_enable = 1'b1; wb_reg_wr_addr = 5'd7; wb_write_data = 32'h12345678;
        tick();
        wb_write_enable = 1'b0;
        drive(20'h500, 5'd7, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        drive(20'h501, 5'd7, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        wb_write_enable = 1'b1; wb_reg_wr_addr = 5'd7; wb_write_data = 32'hDEADBEEF;
        tick();
        idle();
        n_checks++; if (ex_pc !== 20'h500 || ex_data_a !== exp_a) begin n_fail++; $display("FAIL wb_same_cycle: pc %h data_a %h want 500/%h", ex_pc, ex_data_a, exp_a); end
        n_checks++; if (ex_data_b !== 32'h0) begin n_fail++; $display("FAIL wb_r0_b: got %h want 0", ex_data_b); end
        wb_write_enable = 1'b1; wb_reg_wr_addr = 5'd0; wb_write_data = 32'hFFFFFFFF;
        tick();
        wb_write_enable = 1'b0;
        n_checks++; if (ex_pc !== 20'h501 || ex_data_a !== 32'hDEADBEEF || ex_data_b !== 32'h0) begin n_fail++; $display("FAIL wb_next: pc %h a %h b %h want 501/deadbeef/0", ex_pc, ex_data_a, ex_data_b); end
        tick();
    endtask

    task automatic test_reset_midstream();
        ex_ready = 1'b0;
        drive(20'h600, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        for (int i = 1; i < 5; i++) begin
            drive(20'h600 + 20'(i), 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
        end
        n_checks++; if (fifo_count !== 3'd4 || stall_out !== 1'b1 || ex_is_load !== 1'b1) begin n_fail++; $display("FAIL rm_pre: count %0d stall %b ld %b want 4/1/1", fifo_count, stall_out, ex_is_load); end
        rst_n = 1'b0;
        tick();
        n_checks++; if (ex_valid !== 1'b0 || ex_pc !== 20'h0 || ex_rd !== 5'd0 || ex_is_load !== 1'b0 || ex_instruction !== 32'h0) begin n_fail++; $display("FAIL rm_ex_clear: valid %b pc %h rd %0d ld %b instr %h want all 0", ex_valid, ex_pc, ex_rd, ex_is_load, ex_instruction); end
        n_checks++; if (fifo_count !== 3'd0 || if_ready !== 1'b1 || stall_out !== 1'b0) begin n_fail++; $display("FAIL rm_ctrl: count %0d ready %b stall %b want 0/1/0", fifo_count, if_ready, stall_out); end
        rst_n = 1'b1;
        ex_ready = 1'b1;
        drive(20'h610, 5'd9, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++; if (stall_out !== 1'b0 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL rm_sb_cleared: stall %b count %0d want 0/1", stall_out, fifo_count); end
        tick();
        n_checks++; if (ex_pc !== 20'h610 || ex_data_b !== 32'h0) begin n_fail++; $display("FAIL rm_bank_cleared: pc %h data_b %h want 610/0", ex_pc, ex_data_b); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_load_use();
        test_flush();
        test_wb();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
